// File: rtl/inbuff_loader.sv
// inbuff_loader: loads one ifm tile from a valid/ready activation stream into a
// ping-pong input BRAM (two banks of DEPTH words). Zero padding is inserted on
// the edges selected by pad_edge, and each word is written row-major at
// addr = row*W + col of the bank currently being filled.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start / start_ack   tile load request / registered accept pulse
//   ifm_L, ifm_H        unpadded tile width / height, sampled on accept
//   pad_edge            {top, bot, lef, rig} pad enables, sampled on accept
//   s_data/s_valid/
//   s_ready             activation stream
//   wr_en/wr_addr/
//   wr_data             BRAM write port, wr_addr = {bank, in-bank address}
//   tile_ready, rd_bank consumer side: rd_bank holds a complete tile
//   done_tile           consumer finished rd_bank, frees it
//   busy                fill in progress
//   err_cfg             start rejected because of bad geometry
module inbuff_loader #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned DEPTH  = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              start_ack,
    input  logic [9:0]        ifm_L,
    input  logic [9:0]        ifm_H,
    input  logic [3:0]        pad_edge,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              wr_en,
    output logic [ADDR_W:0]   wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              tile_ready,
    output logic              rd_bank,
    input  logic              done_tile,
    output logic              busy,
    output logic              err_cfg
);

    localparam int unsigned DIM_W = 11;
    localparam int unsigned TOT_W = 21;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    // Pad test for a position of the padded tile; pad bits are {top,bot,lef,rig}.
    function automatic logic pad_at(
        input logic [DIM_W-1:0] r,
        input logic [DIM_W-1:0] c,
        input logic [DIM_W-1:0] w,
        input logic [DIM_W-1:0] hp,
        input logic [3:0]       p
    );
        return (p[3] && (r == '0))
            || (p[2] && (r == hp - DIM_W'(1)))
            || (p[1] && (c == '0))
            || (p[0] && (c == w - DIM_W'(1)));
    endfunction

    // Registered state
    state_t            state;
    logic [DIM_W-1:0]  row_q;
    logic [DIM_W-1:0]  col_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DIM_W-1:0]  w_q;
    logic [DIM_W-1:0]  hp_q;
    logic [3:0]        pad_q;
    logic              wr_bank;
    logic [1:0]        bank_full;

    // Next-state values
    state_t            state_nxt;
    logic [DIM_W-1:0]  row_nxt;
    logic [DIM_W-1:0]  col_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DIM_W-1:0]  w_nxt;
    logic [DIM_W-1:0]  hp_nxt;
    logic [3:0]        pad_nxt;
    logic              wr_bank_nxt;
    logic [1:0]        bank_full_nxt;
    logic              rd_bank_nxt;
    logic              start_ack_nxt;
    logic              err_cfg_nxt;
    logic              wr_en_nxt;
    logic [ADDR_W:0]   wr_addr_nxt;
    logic [DATA_W-1:0] wr_data_nxt;

    // Geometry of the requested tile
    logic [DIM_W-1:0]  cfg_w;
    logic [DIM_W-1:0]  cfg_hp;
    logic [TOT_W-1:0]  cfg_total;
    logic              cfg_bad;
    logic              cur_pad;

    always_comb begin
        cfg_w     = DIM_W'(ifm_L) + DIM_W'(pad_edge[1]) + DIM_W'(pad_edge[0]);
        cfg_hp    = DIM_W'(ifm_H) + DIM_W'(pad_edge[3]) + DIM_W'(pad_edge[2]);
        cfg_total = TOT_W'(cfg_w) * TOT_W'(cfg_hp);
        cfg_bad   = (cfg_w == '0) || (cfg_hp == '0) || (cfg_total > TOT_W'(DEPTH));
        cur_pad   = pad_at(row_q, col_q, w_q, hp_q, pad_q);
    end

    // Next-state and write-port logic
    always_comb begin
        state_nxt     = state;
        row_nxt       = row_q;
        col_nxt       = col_q;
        addr_nxt      = addr_q;
        w_nxt         = w_q;
        hp_nxt        = hp_q;
        pad_nxt       = pad_q;
        wr_bank_nxt   = wr_bank;
        bank_full_nxt = bank_full;
        rd_bank_nxt   = rd_bank;
        start_ack_nxt = 1'b0;
        err_cfg_nxt   = 1'b0;
        wr_en_nxt     = 1'b0;
        wr_addr_nxt   = {wr_bank, addr_q};
        wr_data_nxt   = '0;

        case (state)
            IDLE: begin
                // start_ack guard stops a still-high start from being taken twice
                if (start && !start_ack && !bank_full[wr_bank]) begin
                    start_ack_nxt = 1'b1;
                    if (cfg_bad) begin
                        err_cfg_nxt = 1'b1;
                    end else begin
                        w_nxt     = cfg_w;
                        hp_nxt    = cfg_hp;
                        pad_nxt   = pad_edge;
                        row_nxt   = '0;
                        col_nxt   = '0;
                        addr_nxt  = '0;
                        state_nxt = FILL;
                    end
                end
            end

            FILL: begin
                // Pad positions always step; data positions wait for the stream
                if (cur_pad || (s_ready && s_valid)) begin
                    wr_en_nxt   = 1'b1;
                    wr_data_nxt = cur_pad ? '0 : s_data;
                    addr_nxt    = addr_q + ADDR_W'(1);
                    if (col_q == w_q - DIM_W'(1)) begin
                        col_nxt = '0;
                        row_nxt = row_q + DIM_W'(1);
                        if (row_q == hp_q - DIM_W'(1)) begin
                            state_nxt = DONE;
                        end
                    end else begin
                        col_nxt = col_q + DIM_W'(1);
                    end
                end
            end

            DONE: begin
                // Last write is on the port this cycle; publish the bank
                bank_full_nxt[wr_bank] = 1'b1;
                wr_bank_nxt            = ~wr_bank;
                state_nxt              = IDLE;
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Consumer release; never collides with DONE since a filling bank is not full
        if (done_tile && bank_full[rd_bank]) begin
            bank_full_nxt[rd_bank] = 1'b0;
            rd_bank_nxt            = ~rd_bank;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            row_q      <= '0;
            col_q      <= '0;
            addr_q     <= '0;
            w_q        <= '0;
            hp_q       <= '0;
            pad_q      <= '0;
            wr_bank    <= 1'b0;
            bank_full  <= 2'b00;
            rd_bank    <= 1'b0;
            start_ack  <= 1'b0;
            err_cfg    <= 1'b0;
            s_ready    <= 1'b0;
            busy       <= 1'b0;
            tile_ready <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            state      <= state_nxt;
            row_q      <= row_nxt;
            col_q      <= col_nxt;
            addr_q     <= addr_nxt;
            w_q        <= w_nxt;
            hp_q       <= hp_nxt;
            pad_q      <= pad_nxt;
            wr_bank    <= wr_bank_nxt;
            bank_full  <= bank_full_nxt;
            rd_bank    <= rd_bank_nxt;
            start_ack  <= start_ack_nxt;
            err_cfg    <= err_cfg_nxt;
            // Ready is precomputed for the position the fill will sit at next cycle
            s_ready    <= (state_nxt == FILL)
                          && !pad_at(row_nxt, col_nxt, w_nxt, hp_nxt, pad_nxt);
            busy       <= (state_nxt == FILL);
            tile_ready <= bank_full_nxt[rd_bank_nxt];
            wr_en      <= wr_en_nxt;
            wr_addr    <= wr_addr_nxt;
            wr_data    <= wr_data_nxt;
        end
    end

endmodule
